// File: rtl/mvm_host_driver.sv
// Host-side initiator for the mvm_16_1_8_1 multiplier: buffers a load burst from a
// valid/ready stream, replays it gap-free on the MVM pins, and forwards the y burst.
module mvm_host_driver #(
  parameter int MAT_SCALE    = 16,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 2*INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [INPUT_WIDTH-1:0]  src_data,
  output logic                    res_valid,
  output logic                    res_last,
  output logic [OUTPUT_WIDTH-1:0] res_data,
  output logic                    loadMatrix,
  output logic                    loadVector,
  output logic                    start,
  output logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    done,
  input  logic [OUTPUT_WIDTH-1:0] data_out
);
  localparam int DEPTH = MAT_SCALE*MAT_SCALE;
  localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] MAT_LAST = CW'(DEPTH-1);
  localparam logic [CW-1:0] VEC_LAST = CW'(MAT_SCALE-1);

  typedef enum logic [2:0] {IDLE, FILL, PULSE, BURST, GO, WAIT, COLLECT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   is_mat;
  logic [CW-1:0]          last;
  logic [INPUT_WIDTH-1:0] mem [DEPTH];

  assign last      = is_mat ? MAT_LAST : VEC_LAST;
  // Ready is gated by reset so nothing is acknowledged while the block is held.
  assign cmd_ready = (state == IDLE) && !reset;
  assign src_ready = (state == FILL) && !reset;

  always_ff @(posedge clk)
    if (state == FILL && src_valid) mem[cnt] <= src_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_mat     <= 1'b0;
      loadMatrix <= 1'b0;
      loadVector <= 1'b0;
      start      <= 1'b0;
      data_in    <= '0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      res_data   <= '0;
    end else begin
      loadMatrix <= 1'b0;
      loadVector <= 1'b0;
      start      <= 1'b0;
      data_in    <= '0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          case (cmd_op)
            2'd0:    begin is_mat <= 1'b1; cnt <= '0; state <= FILL; end
            2'd1:    begin is_mat <= 1'b0; cnt <= '0; state <= FILL; end
            2'd2:    state <= GO;
            default: state <= IDLE;  // illegal op is consumed and dropped
          endcase
        end
        FILL: if (src_valid) begin
          if (cnt == last) begin
            cnt   <= '0;
            state <= PULSE;
          end else cnt <= cnt + 1'b1;
        end
        PULSE: begin
          loadMatrix <= is_mat;
          loadVector <= !is_mat;
          state      <= BURST;
        end
        BURST: begin
          data_in <= mem[cnt];
          if (cnt == last) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        GO: begin
          start <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (done) begin
          cnt   <= '0;
          state <= COLLECT;
        end
        // y[j] arrives the cycle after done and on each following cycle.
        COLLECT: begin
          res_valid <= 1'b1;
          res_data  <= data_out;
          if (cnt == VEC_LAST) begin
            res_last <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
